// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg: shared UART timing derivation and pacing state encoding.
package uart_tx_feeder_pkg;

    localparam int FRAME_CNT_W = 20;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

    // 10 frame bits plus one bit-time of idle margin before the next start bit
    function automatic int frame_cycles(input int clk_freq, input int uart_bps);
        return 11 * baud_cnt_max(clk_freq, uart_bps);
    endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: producer write port, FIFO status and transmitter strobe bundle.
interface uart_tx_feeder_if #(parameter int FIFO_AW = 8);

    logic               wr_en;
    logic [7:0]         wr_data;
    logic               full;
    logic               empty;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               overflow;
    logic               busy;
    logic [7:0]         po_data;
    logic               po_flag;

    modport master (
        output wr_en, wr_data,
        input  full, empty, fifo_cnt, overflow, busy, po_data, po_flag
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, fifo_cnt, overflow, busy, po_data, po_flag
    );

endinterface

// File: rtl/uart_tx_feeder_fifo_sync.sv
// uart_fifo_sync: register-array byte FIFO with async read and explicit occupancy count.
module uart_fifo_sync #(
    parameter int FIFO_AW = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   cnt,
    output logic               overflow
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               overflow_q, overflow_d;
    logic               wr_ok, rd_ok;

    // a write while full is dropped even when a read frees a slot this cycle
    always_comb begin
        full       = cnt_q == (FIFO_AW+1)'(DEPTH);
        empty      = cnt_q == '0;
        wr_ok      = wr_en && !full;
        rd_ok      = rd_en && !empty;
        wr_ptr_d   = wr_ptr_q + FIFO_AW'(wr_ok);
        rd_ptr_d   = rd_ptr_q + FIFO_AW'(rd_ok);
        cnt_d      = cnt_q + (FIFO_AW+1)'(wr_ok) - (FIFO_AW+1)'(rd_ok);
        overflow_d = wr_en && full;
    end

    assign rd_data  = mem[rd_ptr_q];
    assign cnt      = cnt_q;
    assign overflow = overflow_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers bytes and issues one po_flag strobe per UART frame time.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000,
    parameter int FIFO_AW  = 8
) (
    input logic              sys_clk,
    input logic              sys_rst_n,
    uart_tx_feeder_if.slave  bus
);

    localparam int FRAME_CYCLES = frame_cycles(CLK_FREQ, UART_BPS);

    if (FRAME_CYCLES >= (1 << FRAME_CNT_W)) begin : g_frame_check
        $error("uart_tx_feeder: FRAME_CYCLES does not fit the frame counter");
    end

    state_t                 state_q, state_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]             po_data_q, po_data_d;
    logic                   po_flag_q, po_flag_d;
    logic                   rd_en, empty;
    logic [7:0]             rd_data;

    uart_fifo_sync #(.FIFO_AW(FIFO_AW)) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (bus.wr_en),
        .wr_data   (bus.wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .full      (bus.full),
        .empty     (empty),
        .cnt       (bus.fifo_cnt),
        .overflow  (bus.overflow)
    );

    // dequeue only from IDLE, so each byte owns a whole frame plus the idle cycle
    always_comb begin
        rd_en       = state_q == IDLE && !empty;
        state_d     = state_q == IDLE ? (empty ? IDLE : SEND)
                    : (frame_cnt_q == FRAME_CNT_W'(FRAME_CYCLES - 1) ? IDLE : SEND);
        frame_cnt_d = rd_en ? '0 : (state_q == SEND ? frame_cnt_q + 1'b1 : frame_cnt_q);
        po_data_d   = rd_en ? rd_data : po_data_q;
        po_flag_d   = rd_en;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            po_data_q   <= '0;
            po_flag_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            po_data_q   <= po_data_d;
            po_flag_q   <= po_flag_d;
        end
    end

    assign bus.empty   = empty;
    assign bus.busy    = state_q == SEND;
    assign bus.po_data = po_data_q;
    assign bus.po_flag = po_flag_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed checks of latency, frame spacing, overflow, wrap and reset.
module tb_uart_tx_feeder;

    // 1000 Hz / 250 bps -> BAUD_CNT_MAX 4, frame 44 cycles, strobes 45 apart; depth 16
    localparam int AW  = 4;
    localparam int CF  = 1000;
    localparam int BPS = 250;
    localparam int FC  = 44;
    localparam int SP  = 45;
    localparam logic [17:0] RST_VEC = {8'h00, 3'b000, 5'd0, 2'b10};

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   total     = 0;
    int   bad       = 0;

    uart_tx_feeder_if #(.FIFO_AW(AW)) bus ();

    uart_tx_feeder #(.UART_BPS(BPS), .CLK_FREQ(CF), .FIFO_AW(AW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] val(input int i);
        return 8'(i * 37 + 1);
    endfunction

    task automatic do_reset();
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        obs = {bus.po_data, bus.po_flag, bus.overflow, bus.busy, bus.fifo_cnt, bus.empty, bus.full};
        total++;
        if (obs !== RST_VEC) begin
            bad++;
            $display("FAIL reset_values: got %h want %h", obs, RST_VEC);
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_single();
        int n;
        do_reset();
        bus.wr_data = 8'h55;
        bus.wr_en = 1'b1;
        @(negedge sys_clk);
        bus.wr_en = 1'b0;
        total++;
        if (bus.po_flag !== 1'b0 || bus.fifo_cnt !== 5'd1) begin
            bad++;
            $display("FAIL single_queued: flag=%b cnt=%0d want 0/1", bus.po_flag, bus.fifo_cnt);
        end
        @(negedge sys_clk);
        total++;
        if ({bus.po_flag, bus.po_data, bus.busy, bus.empty} !== {1'b1, 8'h55, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL single_pulse: flag/data/busy/empty=%b/%h/%b/%b want 1/55/1/1",
                     bus.po_flag, bus.po_data, bus.busy, bus.empty);
        end
        n = 1;
        @(negedge sys_clk);
        total++;
        if (bus.po_flag !== 1'b0 || bus.po_data !== 8'h55) begin
            bad++;
            $display("FAIL single_one_shot: flag=%b data=%h want 0/55", bus.po_flag, bus.po_data);
        end
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge sys_clk);
        end
        total++;
        if (n !== FC) begin
            bad++;
            $display("FAIL single_busy_len: got %0d cycles want %0d", n, FC);
        end
        repeat (3) @(negedge sys_clk);
        total++;
        if ({bus.po_flag, bus.po_data, bus.empty, bus.busy} !== {1'b0, 8'h55, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL single_after: flag/data/empty/busy=%b/%h/%b/%b want 0/55/1/0",
                     bus.po_flag, bus.po_data, bus.empty, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int t [2];
        logic [7:0] d [2];
        int k, hold_bad;
        t = '{-1, -1};
        d = '{8'h00, 8'h00};
        k = 0;
        hold_bad = 0;
        do_reset();
        bus.wr_data = 8'hA5;
        bus.wr_en = 1'b1;
        @(negedge sys_clk);
        bus.wr_data = 8'h3C;
        @(negedge sys_clk);
        bus.wr_en = 1'b0;
        for (int c = 0; c < 150; c++) begin
            if (bus.po_flag === 1'b1) begin
                if (k < 2) begin
                    t[k] = c;
                    d[k] = bus.po_data;
                end
                k++;
            end else if (k > 0 && k <= 2 && bus.po_data !== d[k-1]) begin
                hold_bad++;
            end
            @(negedge sys_clk);
        end
        total++;
        if (k !== 2 || t[0] !== 0) begin
            bad++;
            $display("FAIL b2b_pulses: count=%0d first_at=%0d want 2/0", k, t[0]);
        end
        total++;
        if (t[1] - t[0] !== SP) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d want %0d", t[1] - t[0], SP);
        end
        total++;
        if (d[0] !== 8'hA5 || d[1] !== 8'h3C) begin
            bad++;
            $display("FAIL b2b_data: got %h,%h want a5,3c", d[0], d[1]);
        end
        total++;
        if (hold_bad !== 0) begin
            bad++;
            $display("FAIL b2b_hold: po_data changed between strobes %0d times want 0", hold_bad);
        end
    endtask

    task automatic test_overflow();
        int k, ovf;
        do_reset();
        bus.wr_data = 8'hEE;
        bus.wr_en = 1'b1;
        @(negedge sys_clk);
        for (int i = 0; i < 16; i++) begin
            bus.wr_data = 8'(i);
            @(negedge sys_clk);
            if (i == 0) begin
                total++;
                if (bus.po_flag !== 1'b1 || bus.po_data !== 8'hEE) begin
                    bad++;
                    $display("FAIL ovf_pilot: flag=%b data=%h want 1/ee", bus.po_flag, bus.po_data);
                end
            end
        end
        total++;
        if ({bus.full, bus.fifo_cnt, bus.overflow} !== {1'b1, 5'd16, 1'b0}) begin
            bad++;
            $display("FAIL ovf_full: full=%b cnt=%0d ovf=%b want 1/16/0", bus.full, bus.fifo_cnt, bus.overflow);
        end
        bus.wr_data = 8'h77;
        @(negedge sys_clk);
        bus.wr_en = 1'b0;
        total++;
        if ({bus.full, bus.fifo_cnt, bus.overflow} !== {1'b1, 5'd16, 1'b1}) begin
            bad++;
            $display("FAIL ovf_pulse: full=%b cnt=%0d ovf=%b want 1/16/1", bus.full, bus.fifo_cnt, bus.overflow);
        end
        @(negedge sys_clk);
        total++;
        if (bus.overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_one_cycle: ovf=%b want 0", bus.overflow);
        end
        k = 0;
        ovf = 0;
        for (int c = 0; c < 820; c++) begin
            if (bus.overflow === 1'b1) ovf++;
            if (bus.po_flag === 1'b1) begin
                total++;
                if (bus.po_data !== 8'(k)) begin
                    bad++;
                    $display("FAIL ovf_drain_%0d: got %h want %h", k, bus.po_data, 8'(k));
                end
                k++;
            end
            @(negedge sys_clk);
        end
        total++;
        if (k !== 16 || ovf !== 0 || bus.empty !== 1'b1) begin
            bad++;
            $display("FAIL ovf_drain_end: strobes=%0d ovf=%0d empty=%b want 16/0/1", k, ovf, bus.empty);
        end
    endtask

    task automatic test_simul_wrap();
        int n_wr, n_rd;
        logic sim_wr;
        n_wr = 0;
        n_rd = 0;
        sim_wr = 1'b0;
        do_reset();
        for (int c = 0; c < 14000 && n_rd < 300; c++) begin
            if (bus.po_flag === 1'b1) begin
                total++;
                if (bus.po_data !== val(n_rd)) begin
                    bad++;
                    $display("FAIL wrap_data_%0d: got %h want %h", n_rd, bus.po_data, val(n_rd));
                end
                if (sim_wr) begin
                    total++;
                    if (bus.fifo_cnt !== 5'd3) begin
                        bad++;
                        $display("FAIL wrap_cnt_%0d: got %0d want 3", n_rd, bus.fifo_cnt);
                    end
                end
                n_rd++;
            end
            sim_wr = 1'b0;
            if (c < 4 || (n_wr < 300 && bus.busy === 1'b0 && bus.empty === 1'b0)) begin
                sim_wr = c >= 4;
                bus.wr_en = 1'b1;
                bus.wr_data = val(n_wr);
                n_wr++;
            end else begin
                bus.wr_en = 1'b0;
            end
            @(negedge sys_clk);
        end
        bus.wr_en = 1'b0;
        total++;
        if (n_rd !== 300 || n_wr !== 300) begin
            bad++;
            $display("FAIL wrap_count: read=%0d written=%0d want 300/300", n_rd, n_wr);
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] obs;
        int seen;
        do_reset();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.wr_data = 8'(8'h10 + i);
            @(negedge sys_clk);
        end
        bus.wr_en = 1'b0;
        repeat (10) @(negedge sys_clk);
        total++;
        if ({bus.busy, bus.fifo_cnt} !== {1'b1, 5'd5}) begin
            bad++;
            $display("FAIL rstmid_pre: busy=%b cnt=%0d want 1/5", bus.busy, bus.fifo_cnt);
        end
        sys_rst_n = 1'b0;
        #1;
        obs = {bus.po_data, bus.po_flag, bus.overflow, bus.busy, bus.fifo_cnt, bus.empty, bus.full};
        total++;
        if (obs !== RST_VEC) begin
            bad++;
            $display("FAIL rstmid_clear: got %h want %h", obs, RST_VEC);
        end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge sys_clk);
            if (bus.po_flag !== 1'b0 || bus.empty !== 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL rstmid_quiet: %0d cycles with strobe or data want 0", seen);
        end
        bus.wr_data = 8'h42;
        bus.wr_en = 1'b1;
        @(negedge sys_clk);
        bus.wr_en = 1'b0;
        @(negedge sys_clk);
        total++;
        if ({bus.po_flag, bus.po_data} !== {1'b1, 8'h42}) begin
            bad++;
            $display("FAIL rstmid_new: flag=%b data=%h want 1/42", bus.po_flag, bus.po_data);
        end
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.wr_data = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_simul_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
